// File: rtl/msh_pkg.sv
// Shared defaults, payload type and helpers for the mesh read-request arbiter.
package msh_pkg;

    localparam int unsigned MSH_NUM_REQ = 4;
    localparam int unsigned MSH_ADDR_W  = 20;
    localparam int unsigned MSH_TAG_W   = 8;
    localparam int unsigned MSH_NUM_CRD = 8;

    // Source-index width, never narrower than one bit.
    function automatic int unsigned msh_src_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [MSH_ADDR_W-1:0]                 addr;
        logic [MSH_TAG_W-1:0]                  tag;
        logic [msh_src_w(MSH_NUM_REQ)-1:0]     src;
    } msh_rd_req_t;

    typedef enum logic [1:0] {
        CRD_HOLD,
        CRD_TAKE,
        CRD_GIVE,
        CRD_OVF
    } crd_op_e;

endpackage

// File: rtl/msh_rr_arb.sv
// Round-robin search: first set request at or above ptr_i, wrapping at NUM_REQ-1.
module msh_rr_arb
    import msh_pkg::*;
#(
    parameter int unsigned NUM_REQ = MSH_NUM_REQ,
    parameter int unsigned SRC_W   = msh_src_w(MSH_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SRC_W-1:0]   idx_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SRC_W:0]       sum;

    // Rotating the doubled vector puts ptr_i at bit 0, so the first set bit
    // is the winner's offset from the pointer.
    always_comb begin
        dbl   = {req_i, req_i} >> ptr_i;
        rot   = dbl[NUM_REQ-1:0];
        sum   = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                sum   = {1'b0, ptr_i} + (SRC_W+1)'(k);
                if (sum >= (SRC_W+1)'(NUM_REQ)) begin
                    sum = sum - (SRC_W+1)'(NUM_REQ);
                end
                idx_o = sum[SRC_W-1:0];
            end
        end
        gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/msh_rd_req_arb.sv
// Credit-gated round-robin arbiter feeding one registered read-request slot
// toward the mesh node.
module msh_rd_req_arb
    import msh_pkg::*;
#(
    parameter int unsigned NUM_REQ = MSH_NUM_REQ,
    parameter int unsigned ADDR_W  = MSH_ADDR_W,
    parameter int unsigned TAG_W   = MSH_TAG_W,
    parameter int unsigned NUM_CRD = MSH_NUM_CRD,
    localparam int unsigned SRC_W  = msh_src_w(NUM_REQ),
    localparam int unsigned CRD_W  = $clog2(NUM_CRD + 1)
) (
    input  logic                      mclk,
    input  logic                      mrst,
    input  logic [NUM_REQ-1:0]        req_vld,
    output logic [NUM_REQ-1:0]        req_rdy,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [TAG_W-1:0]          out_tag,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      crd_rtn,
    output logic [CRD_W-1:0]          crd_cnt,
    output logic                      crd_err
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic [SRC_W-1:0]  src;
    } rd_req_t;

    logic [ADDR_W-1:0]  addr_a [NUM_REQ];
    logic [TAG_W-1:0]   tag_a  [NUM_REQ];

    logic [NUM_REQ-1:0] arb_gnt;
    logic [SRC_W-1:0]   arb_idx;
    logic               arb_any;
    logic               slot_free;
    logic               may_grant;
    logic               accept;
    crd_op_e            crd_op;

    logic [SRC_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [CRD_W-1:0]   crd_cnt_q, crd_cnt_d;
    logic               crd_err_q, crd_err_d;
    logic               out_vld_q, out_vld_d;
    rd_req_t            out_q,     out_d;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign tag_a[i]  = req_tag[i*TAG_W +: TAG_W];
    end

    msh_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr_arb (
        .req_i (req_vld),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Only the registered count gates granting, so a same-cycle return is
    // not usable until the following cycle.
    assign slot_free = !out_vld_q || out_rdy;
    assign may_grant = slot_free && (crd_cnt_q != '0) && !mrst;
    assign accept    = may_grant && arb_any;
    assign req_rdy   = may_grant ? arb_gnt : '0;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        if (accept) begin
            out_vld_d  = 1'b1;
            out_d.addr = addr_a[arb_idx];
            out_d.tag  = tag_a[arb_idx];
            out_d.src  = arb_idx;
            rr_ptr_d   = (arb_idx == SRC_W'(NUM_REQ - 1)) ? '0 : arb_idx + SRC_W'(1);
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_comb begin
        crd_op = CRD_HOLD;
        if (accept && !crd_rtn) begin
            crd_op = CRD_TAKE;
        end else if (!accept && crd_rtn) begin
            crd_op = (crd_cnt_q == CRD_W'(NUM_CRD)) ? CRD_OVF : CRD_GIVE;
        end
    end

    always_comb begin
        crd_cnt_d = crd_cnt_q;
        crd_err_d = crd_err_q;
        unique case (crd_op)
            CRD_TAKE: crd_cnt_d = crd_cnt_q - CRD_W'(1);
            CRD_GIVE: crd_cnt_d = crd_cnt_q + CRD_W'(1);
            CRD_OVF:  crd_err_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            rr_ptr_q  <= '0;
            crd_cnt_q <= CRD_W'(NUM_CRD);
            crd_err_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            crd_cnt_q <= crd_cnt_d;
            crd_err_q <= crd_err_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_addr = out_q.addr;
    assign out_tag  = out_q.tag;
    assign out_src  = out_q.src;
    assign crd_cnt  = crd_cnt_q;
    assign crd_err  = crd_err_q;

endmodule

// File: tb/tb_msh_rd_req_arb.sv
// Directed and randomized checks of msh_rd_req_arb against a behavioural model.
module tb_msh_rd_req_arb;
    import msh_pkg::*;

    localparam int NR = 4;
    localparam int AW = 20;
    localparam int TW = 8;
    localparam int NC = 8;

    logic            mclk = 1'b0;
    logic            mrst = 1'b1;
    logic [NR-1:0]   req_vld = '0;
    logic [NR-1:0]   req_rdy;
    logic [NR*AW-1:0] req_addr;
    logic [NR*TW-1:0] req_tag;
    logic            out_vld;
    logic            out_rdy = 1'b0;
    logic [AW-1:0]   out_addr;
    logic [TW-1:0]   out_tag;
    logic [1:0]      out_src;
    logic            crd_rtn = 1'b0;
    logic [3:0]      crd_cnt;
    logic            crd_err;

    logic [AW-1:0] addr_a [NR];
    logic [TW-1:0] tag_a  [NR];

    always_comb begin
        req_addr = '0;
        req_tag  = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = addr_a[i];
            req_tag[i*TW +: TW]  = tag_a[i];
        end
    end

    always #5 mclk = ~mclk;

    msh_rd_req_arb #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .TAG_W   (TW),
        .NUM_CRD (NC)
    ) dut (
        .mclk     (mclk),
        .mrst     (mrst),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_addr (req_addr),
        .req_tag  (req_tag),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_addr (out_addr),
        .out_tag  (out_tag),
        .out_src  (out_src),
        .crd_rtn  (crd_rtn),
        .crd_cnt  (crd_cnt),
        .crd_err  (crd_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_grant_seen = 0;

    // Behavioural model state
    bit          m_ovld;
    msh_rd_req_t m_pl;
    int          m_ptr;
    int          m_crd;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (mrst) return -1;
        if (m_ovld && !out_rdy) return -1;
        if (m_crd == 0) return -1;
        for (int k = 0; k < NR; k++) begin
            int s;
            s = (m_ptr + k) % NR;
            if (req_vld[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ovld = 0;
        m_pl   = '0;
        m_ptr  = 0;
        m_crd  = NC;
        m_err  = 0;
    endtask

    task automatic model_step();
        int g;
        g = exp_grant();
        if (g >= 0) begin
            m_ovld    = 1;
            m_pl.addr = addr_a[g];
            m_pl.tag  = tag_a[g];
            m_pl.src  = 2'(g);
            m_ptr     = (g + 1) % NR;
        end else if (out_rdy) begin
            m_ovld = 0;
        end
        if (g >= 0 && !crd_rtn) m_crd--;
        else if (g < 0 && crd_rtn) begin
            if (m_crd == NC) m_err = 1;
            else m_crd++;
        end
    endtask

    task automatic check_all();
        int g;
        g = exp_grant();
        chk("req_rdy", 32'(req_rdy), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("out_vld", 32'(out_vld), 32'(m_ovld));
        chk("out_addr", 32'(out_addr), 32'(m_pl.addr));
        chk("out_tag", 32'(out_tag), 32'(m_pl.tag));
        chk("out_src", 32'(out_src), 32'(m_pl.src));
        chk("crd_cnt", 32'(crd_cnt), 32'(m_crd));
        chk("crd_err", 32'(crd_err), 32'(m_err));
        if (req_rdy != '0) n_grant_seen++;
    endtask

    // Entered and left at posedge+1; inputs must already be driven.
    task automatic cycle();
        #3;
        check_all();
        @(posedge mclk);
        if (!mrst) model_step();
        #1;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < NR; i++) begin
            addr_a[i] = AW'($urandom);
            tag_a[i]  = TW'($urandom);
        end
    endtask

    task automatic do_reset();
        mrst = 1'b1;
        #1;
        model_reset();
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_crd_cnt", 32'(crd_cnt), 32'(NC));
        chk("rst_crd_err", 32'(crd_err), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        @(posedge mclk);
        #1;
        mrst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] held_addr;
        logic [TW-1:0] held_tag;
        int            g0;

        rand_payload();
        model_reset();
        @(posedge mclk);
        #1;
        do_reset();

        // Round robin across all sources with credits refilled every cycle
        req_vld = 4'hF; out_rdy = 1'b1; crd_rtn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            cycle();
            chk("rr_seq_src", 32'(out_src), 32'(i % NR));
            chk("rr_seq_vld", 32'(out_vld), 32'd1);
        end
        chk("rr_seq_crd", 32'(crd_cnt), 32'(NC));

        // Backpressure holds the slot stable
        crd_rtn = 1'b0;
        do_reset();
        req_vld = 4'b0100; out_rdy = 1'b0;
        rand_payload();
        cycle();
        held_addr = addr_a[2];
        held_tag  = tag_a[2];
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            cycle();
            chk("hold_vld", 32'(out_vld), 32'd1);
            chk("hold_src", 32'(out_src), 32'd2);
            chk("hold_addr", 32'(out_addr), 32'(held_addr));
            chk("hold_tag", 32'(out_tag), 32'(held_tag));
            chk("hold_crd", 32'(crd_cnt), 32'd7);
        end

        // Credit exhaustion and single-credit recovery
        do_reset();
        req_vld = 4'hF; out_rdy = 1'b1; crd_rtn = 1'b0;
        for (int i = 0; i < NC; i++) begin
            rand_payload();
            cycle();
        end
        chk("exhaust_crd", 32'(crd_cnt), 32'd0);
        g0 = n_grant_seen;
        crd_rtn = 1'b1;
        cycle();
        crd_rtn = 1'b0;
        chk("rtn_crd", 32'(crd_cnt), 32'd1);
        cycle();
        cycle();
        chk("one_grant", 32'(n_grant_seen - g0), 32'd1);
        chk("regrant_crd", 32'(crd_cnt), 32'd0);

        // Accept and return in the same cycle
        do_reset();
        req_vld = 4'hF; out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("five_crd", 32'(crd_cnt), 32'd3);
        crd_rtn = 1'b1;
        cycle();
        crd_rtn = 1'b0;
        chk("same_cyc_crd", 32'(crd_cnt), 32'd3);
        chk("same_cyc_vld", 32'(out_vld), 32'd1);

        // Credit overflow is sticky
        do_reset();
        req_vld = '0; crd_rtn = 1'b1;
        cycle();
        crd_rtn = 1'b0;
        chk("ovf_crd", 32'(crd_cnt), 32'(NC));
        chk("ovf_err", 32'(crd_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            req_vld = 4'(i + 1);
            cycle();
            chk("ovf_sticky", 32'(crd_err), 32'd1);
        end

        // Reset mid-stream drops in-flight request
        do_reset();
        req_vld = 4'hF; out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            cycle();
        end
        chk("pre_rst_vld", 32'(out_vld), 32'd1);
        mrst = 1'b1;
        #1;
        model_reset();
        chk("midrst_vld", 32'(out_vld), 32'd0);
        chk("midrst_crd", 32'(crd_cnt), 32'(NC));
        chk("midrst_rdy", 32'(req_rdy), 32'd0);
        @(posedge mclk);
        #1;
        mrst = 1'b0;
        req_vld = 4'b1010;
        cycle();
        chk("post_rst_src", 32'(out_src), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            rand_payload();
            req_vld = 4'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            crd_rtn = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msh_rd_req_arb.md
MSH_RD_REQ_ARB -- requirements
Module: msh_rd_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read-request sources (2..8).
REQ-002 SHALL have parameter ADDR_W, default 20, request address width.
REQ-003 SHALL have parameter TAG_W, default 8, request tag width.
REQ-004 SHALL have parameter NUM_CRD, default 8, downstream read-request credits (1..15).
REQ-005 SHALL have port mclk  in  1  mesh clock; the block uses one clock, all flops rising-edge.
REQ-006 SHALL have port mrst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_vld  in  NUM_REQ  per-source request valid.
REQ-008 SHALL have port req_rdy  out  NUM_REQ  per-source accept, at most one bit set.
REQ-009 SHALL have port req_addr  in  NUM_REQ*ADDR_W  per-source address, source i at slice i.
REQ-010 SHALL have port req_tag  in  NUM_REQ*TAG_W  per-source tag, source i at slice i.
REQ-011 SHALL have port out_vld  out  1  registered request valid toward mesh node.
REQ-012 SHALL have port out_rdy  in  1  mesh node accepts out_* this cycle.
REQ-013 SHALL have ports out_addr/out_tag/out_src  out  ADDR_W/TAG_W/SRC_W  registered payload and granted source index.
REQ-014 SHALL have port crd_rtn  in  1  one-cycle pulse returning one credit.
REQ-015 SHALL have ports crd_cnt  out  CRD_W  available credits, and crd_err  out  1  sticky overflow error.

Function
REQ-016 SHALL define slot_free = !out_vld | out_rdy and may_grant = slot_free & (crd_cnt != 0).
REQ-017 SHALL, when may_grant, set req_rdy one-hot for the first valid source found searching from rr_ptr upward with wrap at NUM_REQ-1 to 0; otherwise req_rdy = 0.
REQ-018 SHALL let req_rdy depend combinationally on req_vld; sources SHALL NOT make req_vld depend on req_rdy.
REQ-019 SHALL, on accept at cycle t, load out_addr/out_tag/out_src from the granted source and assert out_vld at t+1 (latency 1).
REQ-020 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ on accept; rr_ptr unchanged when no accept.
REQ-021 SHALL hold out_* stable while out_vld & !out_rdy; SHALL clear out_vld after out_rdy with no new accept.
REQ-022 SHALL sustain one request per cycle when out_rdy = 1 and credits remain (back-to-back load on drain).
REQ-023 SHALL decrement crd_cnt by 1 per accept, increment by 1 per crd_rtn; both in one cycle leave it unchanged.
REQ-024 SHALL, when crd_rtn arrives with crd_cnt = NUM_CRD and no accept, hold crd_cnt at NUM_CRD and set crd_err (sticky until reset).
REQ-025 SHALL use a credit returned in cycle t for granting no earlier than cycle t+1.
REQ-026 SHALL size SRC_W = max(1, clog2(NUM_REQ)) and CRD_W = clog2(NUM_CRD+1).

Reset
REQ-027 SHALL on mrst asynchronously force out_vld = 0, out_addr/out_tag/out_src = 0, rr_ptr = 0, crd_cnt = NUM_CRD, crd_err = 0.
REQ-028 SHALL drive req_rdy = 0 while mrst is asserted; a request held through reset is re-arbitrated after deassertion; an in-flight out_vld is dropped.

Structure
REQ-029 SHALL place the NUM_REQ/ADDR_W/TAG_W/NUM_CRD defaults and the read-request payload struct (addr, tag, src) in msh_pkg.
REQ-030 SHALL implement the round-robin search as sub-module msh_rr_arb (req vector, ptr in; one-hot grant, index out).

Verification
REQ-031 SHALL cover: all 4 req_vld held high, out_rdy = 1, credits refilled each cycle -> out_src sequence 0,1,2,3,0, one per cycle.
REQ-032 SHALL cover: source 2 only, out_rdy = 0 for 3 cycles -> out_vld stays 1, payload stable, req_rdy = 0, crd_cnt = 7.
REQ-033 SHALL cover: 8 accepts, no crd_rtn -> crd_cnt = 0, req_rdy = 0; one crd_rtn pulse -> exactly one grant the following cycle.
REQ-034 SHALL cover: accept and crd_rtn in same cycle with crd_cnt = 3 -> crd_cnt stays 3.
REQ-035 SHALL cover: crd_rtn at crd_cnt = 8 -> crd_cnt = 8, crd_err = 1 until mrst.
REQ-036 SHALL cover: mrst asserted mid-stream with out_vld = 1 -> out_vld = 0, crd_cnt = 8, rr_ptr = 0 immediately; first grant after release goes to lowest-index valid source.
